// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Streams a bitstream, one byte at a time, into the ccff_head of a
//   configuration-memory chain. It gates the chain's prog_clk through chain_en
//   so that the chain shifts exactly CHAIN_LEN times per load. The bits that
//   emerge at ccff_tail (the previous chain contents) are returned as a
//   readback byte stream.
//
// Parameters
//   CHAIN_LEN  number of configuration flops in the chain (>= 1)
//   CNT_W      remaining-bit counter width, 2**CNT_W > CHAIN_LEN
//
// Ports
//   prog_clk   in   controller clock; the chain runs on its gated copy
//   pReset     in   synchronous active-high reset
//   start      in   load request, honoured in IDLE/DONE only
//   cfg_data   in   [7:0] bitstream byte, MSB shifted first
//   cfg_valid  in   cfg_data valid
//   cfg_ready  out  byte accepted this cycle (high in LOAD)
//   ccff_head  out  registered serial data into the chain
//   chain_en   out  registered gate enable; chain shifts on edges where it is 1
//   ccff_tail  in   serial data out of the chain
//   busy       out  high in LOAD or SHIFT
//   done       out  high in DONE
//   rb_data    out  [7:0] readback byte, first-emerging bit in the MSB
//   rb_valid   out  one-cycle strobe qualifying rb_data, no backpressure
//   dbg_state  out  [1:0] current FSM state (0 IDLE, 1 LOAD, 2 SHIFT, 3 DONE)
//
// Handshake: a byte transfers on a rising edge where cfg_valid=1 and
// cfg_ready=1. cfg_ready depends only on the state, never on cfg_valid, and a
// source may hold cfg_valid with stable data for as long as it needs; bytes
// offered outside LOAD are simply not taken.

module ccff_chain_loader #(
  parameter int CHAIN_LEN = 30,
  parameter int CNT_W     = 5
) (
  input  logic       prog_clk,
  input  logic       pReset,
  input  logic       start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       ccff_head,
  output logic       chain_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

  state_t           state_q;
  logic [7:0]       shreg_q;      // bits of the current byte still to be shifted
  logic [CNT_W-1:0] remaining_q;  // chain bits still to be shifted in this load
  logic [2:0]       bit_left_q;   // bits of the current byte after the one on ccff_head
  logic             head_q;
  logic             en_q;
  logic [7:0]       rb_sh_q;
  logic [2:0]       rb_cnt_q;     // readback samples collected in the current byte
  logic [7:0]       rb_data_q;
  logic             rb_valid_q;

  logic [31:0]      rem_ext;
  logic [2:0]       nbits_m1_d;
  logic [7:0]       rb_shift_d;
  logic [7:0]       rb_align_d;
  logic             last_bit_d;

  // Number of bits taken from the byte being accepted, minus one:
  // min(8, remaining) - 1. Only the top bits of a final partial byte are used.
  assign rem_ext    = 32'(remaining_q);
  assign nbits_m1_d = (rem_ext >= 32'd8) ? 3'd7 : 3'(rem_ext - 32'd1);

  // Readback byte including this edge's ccff_tail sample. For a short final
  // byte the collected bits are moved up to the MSB end and zero padded; for a
  // full byte (rb_cnt_q == 7) the shift amount is zero.
  assign rb_shift_d = {rb_sh_q[6:0], ccff_tail};
  assign rb_align_d = rb_shift_d << (3'd7 - rb_cnt_q);
  assign last_bit_d = (remaining_q == ONE_C);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      remaining_q <= '0;
      bit_left_q  <= '0;
      head_q      <= 1'b0;
      en_q        <= 1'b0;
      rb_sh_q     <= '0;
      rb_cnt_q    <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_LOAD;
            remaining_q <= CHAIN_LEN_C;
            rb_cnt_q    <= '0;
          end
        end

        S_LOAD: begin
          // The MSB goes straight onto ccff_head together with chain_en, so
          // the chain takes it on the first SHIFT edge.
          if (cfg_valid) begin
            state_q    <= S_SHIFT;
            head_q     <= cfg_data[7];
            en_q       <= 1'b1;
            shreg_q    <= {cfg_data[6:0], 1'b0};
            bit_left_q <= nbits_m1_d;
          end
        end

        S_SHIFT: begin
          // The chain shifts on this edge: count the bit and capture ccff_tail.
          remaining_q <= remaining_q - ONE_C;
          rb_sh_q     <= rb_shift_d;
          rb_cnt_q    <= rb_cnt_q + 3'd1;
          if (rb_cnt_q == 3'd7 || last_bit_d) begin
            rb_data_q  <= rb_align_d;
            rb_valid_q <= 1'b1;
          end

          if (bit_left_q == 3'd0) begin
            en_q    <= 1'b0;
            head_q  <= 1'b0;
            state_q <= last_bit_d ? S_DONE : S_LOAD;
          end else begin
            head_q     <= shreg_q[7];
            shreg_q    <= {shreg_q[6:0], 1'b0};
            bit_left_q <= bit_left_q - 3'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign ccff_head = head_q;
  assign chain_en  = en_q;
  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 30-flop instance and an 8-flop instance,
// each attached to a behavioural model of its configuration chain.

module tb_ccff_chain_loader;

  localparam int L0 = 30;
  localparam int L1 = 8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // ---------------- clock / reset ----------------
  logic prog_clk = 1'b0;
  logic pReset;
  always #5 prog_clk = ~prog_clk;

  // ---------------- DUT0 (CHAIN_LEN = 30) ----------------
  logic       start, cfg_valid, cfg_ready, ccff_head, chain_en, ccff_tail;
  logic       busy, done, rb_valid;
  logic [7:0] cfg_data, rb_data;
  logic [1:0] dbg_state;

  ccff_chain_loader #(.CHAIN_LEN(L0), .CNT_W(5)) dut0 (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .start    (start),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .ccff_head(ccff_head),
    .chain_en (chain_en),
    .ccff_tail(ccff_tail),
    .busy     (busy),
    .done     (done),
    .rb_data  (rb_data),
    .rb_valid (rb_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT1 (CHAIN_LEN = 8) ----------------
  logic       start1, cfg_valid1, cfg_ready1, ccff_head1, chain_en1, ccff_tail1;
  logic       busy1, done1, rb_valid1;
  logic [7:0] cfg_data1, rb_data1;
  logic [1:0] dbg_state1;

  ccff_chain_loader #(.CHAIN_LEN(L1), .CNT_W(4)) dut1 (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .start    (start1),
    .cfg_data (cfg_data1),
    .cfg_valid(cfg_valid1),
    .cfg_ready(cfg_ready1),
    .ccff_head(ccff_head1),
    .chain_en (chain_en1),
    .ccff_tail(ccff_tail1),
    .busy     (busy1),
    .done     (done1),
    .rb_data  (rb_data1),
    .rb_valid (rb_valid1),
    .dbg_state(dbg_state1)
  );

  // ---------------- chain models ----------------
  logic [L0-1:0] chain0 = '0;
  logic [L1-1:0] chain1 = '0;
  always @(posedge prog_clk) if (chain_en === 1'b1) chain0 <= {chain0[L0-2:0], ccff_head};
  always @(posedge prog_clk) if (chain_en1 === 1'b1) chain1 <= {chain1[L1-2:0], ccff_head1};
  assign ccff_tail  = chain0[L0-1];
  assign ccff_tail1 = chain1[L1-1];

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [0:0] head_exp_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  logic [7:0] stim[4];
  int  en_cnt  = 0;
  int  rb1_cnt = 0;
  bit  mon_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge prog_clk) begin
    if (mon_en) begin
      if (chain_en === 1'b1) begin
        en_cnt++;
        if (head_exp_q.size() == 0) check("head_extra_shift", head_exp_q.size(), 1);
        else check("ccff_head", ccff_head, head_exp_q.pop_front());
      end
      if (rb_valid === 1'b1) begin
        if (exp_q.size() == 0) check("rb_extra_byte", exp_q.size(), 1);
        else check("rb_data", rb_data, exp_q.pop_front());
      end
    end
    if (rb_valid1 === 1'b1) begin
      rb1_cnt++;
      if (exp1_q.size() == 0) check("rb1_extra_byte", exp1_q.size(), 1);
      else check("rb1_data", rb_data1, exp1_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_ccff_head", ccff_head, 0);
    check("rst_chain_en",  chain_en,  0);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    check("rst_rb_data",   rb_data,   0);
    check("rst_rb_valid",  rb_valid,  0);
    check("rst_state",     dbg_state, ST_IDLE);
  endtask

  // Expected readback of the next load: the modelled chain contents, oldest bit first.
  task automatic push_snapshot();
    logic [7:0] v;
    for (int b = 0; b < 4; b++) begin
      v = 8'h00;
      for (int k = 0; k < 8; k++)
        if (8 * b + k < L0) v[7-k] = chain0[L0-1-(8*b+k)];
      exp_q.push_back(v);
    end
  endtask

  task automatic do_load(input int stall, input bit pulse_start);
    int base, n, t, rem;
    base = en_cnt;
    rem  = L0;
    n    = 0;
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_data  = stim[i];
      cfg_valid = (stall == 0);
      t = 0;
      while (cfg_ready !== 1'b1 && t < 50) begin
        @(negedge prog_clk);
        t++;
      end
      check("ready_wait", cfg_ready, 1);
      for (int s = 0; s < stall; s++) begin
        check("stall_ready", cfg_ready, 1);
        check("stall_chain_en", chain_en, 0);
        @(negedge prog_clk);
      end
      cfg_valid = 1'b1;
      n = (rem >= 8) ? 8 : rem;
      for (int j = 0; j < n; j++) head_exp_q.push_back(stim[i][7-j]);
      rem -= n;
      @(negedge prog_clk);
      if (pulse_start && i == 1) begin
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
      end
    end
    cfg_valid = 1'b0;
    repeat (n) @(negedge prog_clk);
    check("done_after_last", done, 1);
    check("done_chain_en", chain_en, 0);
    check("done_busy", busy, 0);
    check("done_state", dbg_state, ST_DONE);
    @(posedge prog_clk);
    check("chain_en_total", en_cnt - base, L0);
    check("head_q_drained", head_exp_q.size(), 0);
    check("rb_q_drained", exp_q.size(), 0);
  endtask

  task automatic do_load1(input logic [7:0] b);
    int base;
    base = rb1_cnt;
    @(negedge prog_clk); start1 = 1'b1;
    @(negedge prog_clk); start1 = 1'b0;
    cfg_data1  = b;
    cfg_valid1 = 1'b1;
    check("l8_ready", cfg_ready1, 1);
    @(negedge prog_clk);
    cfg_valid1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("l8_chain_en", chain_en1, 1);
      check("l8_head", ccff_head1, b[7-k]);
      @(negedge prog_clk);
    end
    check("l8_done", done1, 1);
    check("l8_chain_en_off", chain_en1, 0);
    @(posedge prog_clk);
    check("l8_rb_pulses", rb1_cnt - base, 1);
    check("l8_rb_q_drained", exp1_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    pReset = 1'b1;
    start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    start1 = 1'b0; cfg_valid1 = 1'b0; cfg_data1 = 8'h00;
    repeat (3) @(negedge prog_clk);
    check_reset_outputs();
    check("l8_rst_state", dbg_state1, ST_IDLE);
    pReset = 1'b0;

    // Load interrupted by a 3-cycle reset in the middle of SHIFT.
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0; cfg_data = 8'hA5; cfg_valid = 1'b1;
    repeat (5) @(negedge prog_clk);
    check("abort_in_shift", dbg_state, ST_SHIFT);
    pReset = 1'b1; cfg_valid = 1'b0;
    @(negedge prog_clk);
    check_reset_outputs();
    repeat (2) @(negedge prog_clk);
    check_reset_outputs();
    pReset = 1'b0;

    // cfg_valid in IDLE must not be taken.
    mon_en = 1'b1;
    cfg_data = 8'h55; cfg_valid = 1'b1;
    repeat (4) begin
      @(negedge prog_clk);
      check("idle_ready", cfg_ready, 0);
      check("idle_chain_en", chain_en, 0);
      check("idle_state", dbg_state, ST_IDLE);
    end
    cfg_valid = 1'b0;

    // Full reload of zeros; readback is whatever the interrupted load left.
    push_snapshot();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_load(0, 1'b0);

    // Stalled load with a start pulse during SHIFT; chain held all zeros.
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    stim = '{8'hA5, 8'h3C, 8'hF0, 8'hFF};
    do_load(5, 1'b1);

    // Back-to-back load; reads back the previous bitstream, last byte padded.
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    exp_q.push_back(8'hF0); exp_q.push_back(8'hFC);
    stim = '{8'h3C, 8'h00, 8'hFF, 8'h81};
    do_load(0, 1'b0);

    // CHAIN_LEN = 8 instance.
    exp1_q.push_back(8'h00);
    do_load1(8'h81);
    exp1_q.push_back(8'h81);
    do_load1(8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain controller that streams a bitstream, byte by byte, into the ccff_head of a chain of configuration memories (switch/connection block mux mems), then stops.
- Drives an enable for the chain's prog_clk gate so the chain shifts exactly CHAIN_LEN times per load.
- Captures the bits emerging at ccff_tail, i.e. the previous chain contents, as a readback byte stream.
- Sits between the host/bitstream source and the ccff_head/ccff_tail of a tile's configuration chain.

Parameters:
- CHAIN_LEN, 30: number of configuration flops in the chain (3 size3 mems × 2 bits + 4 size4 mems × 6 bits). Legal range ≥ 1.
- CNT_W, 5: width of the remaining-bit counter. Must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk, input, 1: the single clock. The controller runs on it; the chain is clocked by its gated copy.
- pReset, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle load request. Honoured only in IDLE or DONE.
- cfg_data, input, 8: bitstream byte, MSB shifted first.
- cfg_valid, input, 1: cfg_data is valid.
- cfg_ready, output, 1: controller accepts a byte this cycle.
- ccff_head, output, 1: serial data into the chain. Registered.
- chain_en, output, 1: gate enable. The chain shifts on every prog_clk rising edge where chain_en=1. Registered.
- ccff_tail, input, 1: serial data out of the chain.
- busy, output, 1: high in LOAD or SHIFT.
- done, output, 1: high in DONE.
- rb_data, output, 8: readback byte, first-emerging bit in the MSB.
- rb_valid, output, 1: one-cycle strobe qualifying rb_data. No backpressure.

Behaviour:
- Reset (pReset=1 at a rising edge) from any state, including mid-shift:
  - state=IDLE.
  - cfg_ready=0, ccff_head=0, chain_en=0, busy=0, done=0, rb_data=0x00, rb_valid=0.
  - Internal counters cleared.
  - A partially shifted chain is left as-is; a new start reloads the whole chain.
- IDLE / DONE:
  - start=1 → next cycle LOAD, done=0, remaining=CHAIN_LEN, rb bit counter=0.
  - start=0 → state held (DONE keeps done=1).
- LOAD:
  - cfg_ready=1 combinationally from state; chain_en=0.
  - cfg_valid=1 → byte latched into an 8-bit shifter, n=min(8, remaining), next state SHIFT.
  - cfg_valid=0 → wait indefinitely. No timeout.
- SHIFT:
  - For n consecutive cycles, chain_en=1 and ccff_head = current shifter MSB. The shifter shifts left after each bit.
  - remaining decrements once per shifted bit.
  - After the n-th bit: remaining=0 → DONE; otherwise → LOAD.
  - chain_en and ccff_head are registered together, so they change only just after a rising edge and are stable at the edge where the chain samples them.
- Partial last byte: when CHAIN_LEN mod 8 ≠ 0, only the top (CHAIN_LEN mod 8) bits of the final byte are shifted; its low bits are discarded.
- Exactly CHAIN_LEN chain_en cycles per load.
- Throughput per byte: 1 handshake cycle + n shift cycles.
- Readback:
  - On every edge where chain_en=1, ccff_tail is sampled into an rb shifter, MSB first.
  - After every 8 samples, rb_data is updated and rb_valid pulses for 1 cycle.
  - After the final bit of a load with a partial count, the byte is left-aligned and zero-padded in the low bits, with a 1-cycle rb_valid.
  - rb_valid never overlaps reset.
- start asserted while busy: ignored.
- cfg_valid outside LOAD: ignored, byte not consumed.
- start and pReset in the same cycle: pReset wins.

Test Plan:
- Reset values: pReset held 3 cycles mid-SHIFT → all outputs 0, state IDLE. The next load still produces exactly 30 chain_en cycles.
- Basic load, CHAIN_LEN=30, bench models a 30-bit chain:
  - start, then bytes 0xA5, 0x3C, 0xF0, 0xFF with cfg_valid always high.
  - ccff_head sequence = 1010_0101 0011_1100 1111_0000 1111_11; chain_en high for exactly 30 cycles.
  - done=1 in the cycle after the last shift; the last byte's low 2 bits are unused.
- Readback:
  - First, a load of all 0x00 bytes → chain = 0, so the rb bytes of the following load are 0x00, 0x00, 0x00, 0x00.
  - Then reload with 0xA5, 0x3C, 0xF0, 0xFF; a third load then returns rb bytes 0xA5, 0x3C, 0xF0, 0xFC (partial byte padded).
- Stalls: cfg_valid deasserted for 5 cycles before each byte → cfg_ready held high, chain_en=0 throughout each stall, ccff_head sequence unchanged.
- Ignored requests:
  - start pulsed during SHIFT → no restart, chain_en total still 30.
  - cfg_valid high in IDLE → no byte consumed.
- CHAIN_LEN=8 variant: one byte 0x81 → 8 chain_en cycles, done 1 cycle later, one rb_valid pulse.
